// File: rtl/compare_arbiter.sv
// compare_arbiter: shares one external combinational comparison unit between
// two requesters. A request is sampled in IDLE. The winner's operands are
// latched onto the cmp_* bus in ISSUE. The comparator result is captured with
// a one-cycle ack in RESP.
//
// Optional build macro: CMP_ARB_RR_EN
//   defined   -> round-robin on simultaneous requests (grant != last_grant)
//   undefined -> fixed priority, requester 0 wins contention
//
// Handshake: reqN is held high until ackN. ackN is a single-cycle pulse, and
// res/res_id are valid for requester N in the cycle ackN is high. A req still
// high after its ack is taken as a fresh request in the next IDLE cycle.
// Operands must be stable while req is high. They are latched at grant, so
// later changes do not affect the transaction in flight.
module compare_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] x0,
  input  logic [3:0] y0,
  input  logic [3:0] x1,
  input  logic [3:0] y1,
  input  logic [1:0] mode0,
  input  logic [1:0] mode1,
  input  logic       of0,
  input  logic       of1,
  output logic       ack0,
  output logic       ack1,
  output logic [8:0] res,
  output logic       res_id,
  output logic       busy,
  output logic [3:0] cmp_x,
  output logic [3:0] cmp_y,
  output logic [1:0] cmp_mode,
  output logic       cmp_of,
  input  logic [8:0] cmp_out,
  output logic [7:0] txn_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic [8:0] res_q, res_d;
  logic       res_id_q, res_id_d;
  logic       busy_q, busy_d;
  logic [3:0] cmp_x_q, cmp_x_d;
  logic [3:0] cmp_y_q, cmp_y_d;
  logic [1:0] cmp_mode_q, cmp_mode_d;
  logic       cmp_of_q, cmp_of_d;
  logic [7:0] txn_cnt_q, txn_cnt_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       any_req;
  logic       winner;

  // Arbitration: pick which requester would be granted if IDLE this cycle
  always_comb begin
    any_req = req0 | req1;
    winner  = 1'b0;
    if (req0 && req1) begin
`ifdef CMP_ARB_RR_EN
      winner = ~last_grant_q;
`else
      winner = 1'b0;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  // Next-state and next-output computation; everything holds by default
  always_comb begin
    state_d      = state_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    res_d        = res_q;
    res_id_d     = res_id_q;
    cmp_x_d      = cmp_x_q;
    cmp_y_d      = cmp_y_q;
    cmp_mode_d   = cmp_mode_q;
    cmp_of_d     = cmp_of_q;
    txn_cnt_d    = txn_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d      = winner;
          last_grant_d = winner;
          if (winner) begin
            cmp_x_d    = x1;
            cmp_y_d    = y1;
            cmp_mode_d = mode1;
            cmp_of_d   = of1;
          end else begin
            cmp_x_d    = x0;
            cmp_y_d    = y0;
            cmp_mode_d = mode0;
            cmp_of_d   = of0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The cmp_* bus has been stable for a full cycle, so cmp_out is settled
        res_d     = cmp_out;
        res_id_d  = grant_q;
        ack0_d    = ~grant_q;
        ack1_d    = grant_q;
        txn_cnt_d = txn_cnt_q + 8'd1;
        state_d   = S_RESP;
      end
      S_RESP: begin
        // Requests are not sampled here, so the ack pulse cannot re-trigger
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      res_q        <= 9'h000;
      res_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      cmp_x_q      <= 4'd0;
      cmp_y_q      <= 4'd0;
      cmp_mode_q   <= 2'd0;
      cmp_of_q     <= 1'b0;
      txn_cnt_q    <= 8'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      res_q        <= res_d;
      res_id_q     <= res_id_d;
      busy_q       <= busy_d;
      cmp_x_q      <= cmp_x_d;
      cmp_y_q      <= cmp_y_d;
      cmp_mode_q   <= cmp_mode_d;
      cmp_of_q     <= cmp_of_d;
      txn_cnt_q    <= txn_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;
  assign cmp_x     = cmp_x_q;
  assign cmp_y     = cmp_y_q;
  assign cmp_mode  = cmp_mode_q;
  assign cmp_of    = cmp_of_q;
  assign txn_cnt   = txn_cnt_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed table vectors plus hand-written sequences for
// contention, operand latching, mid-transaction reset and counter wrap.
module tb_compare_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] x0, y0, x1, y1;
  logic [1:0] mode0, mode1;
  logic       of0, of1;
  logic       ack0, ack1;
  logic [8:0] res;
  logic       res_id;
  logic       busy;
  logic [3:0] cmp_x, cmp_y;
  logic [1:0] cmp_mode;
  logic       cmp_of;
  logic [8:0] cmp_out;
  logic [7:0] txn_cnt;
  logic [1:0] state_dbg;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_cnt;

  compare_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .mode0(mode0), .mode1(mode1),
    .of0(of0), .of1(of1),
    .ack0(ack0), .ack1(ack1),
    .res(res), .res_id(res_id), .busy(busy),
    .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_mode(cmp_mode), .cmp_of(cmp_of),
    .cmp_out(cmp_out), .txn_cnt(txn_cnt), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Stand-in for the external comparison unit
  always_comb begin
    cmp_out = {cmp_of, 8'h00};
    case (cmp_mode)
      2'd0: cmp_out[0] = (cmp_x == cmp_y);
      2'd1: cmp_out[0] = (cmp_x > cmp_y);
      2'd2: cmp_out[0] = (cmp_x < cmp_y);
      default: cmp_out[3:0] = (cmp_x > cmp_y) ? cmp_x : cmp_y;
    endcase
  end

  typedef struct packed {
    logic       r0;
    logic       r1;
    logic [3:0] vx0;
    logic [3:0] vy0;
    logic [1:0] m0;
    logic       o0;
    logic [3:0] vx1;
    logic [3:0] vy1;
    logic [1:0] m1;
    logic       o1;
    logic       eid;
    logic [8:0] eres;
  } vec_t;

  vec_t vecs [0:8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Requests are already driven and the DUT is IDLE; walk E0, E1, E2
  task automatic run_txn(input logic eid, input logic [8:0] eres);
    step;  // E0: sampled, now ISSUE
    chk("busy_e0", {15'd0, busy}, 16'd1);
    chk("acks_e0", {14'd0, ack1, ack0}, 16'd0);
    step;  // E1: result captured, ack pulses
    exp_cnt = exp_cnt + 8'd1;
    chk("ack0_e1", {15'd0, ack0}, {15'd0, ~eid});
    chk("ack1_e1", {15'd0, ack1}, {15'd0, eid});
    chk("res_e1", {7'd0, res}, {7'd0, eres});
    chk("res_id_e1", {15'd0, res_id}, {15'd0, eid});
    chk("txn_cnt_e1", {8'd0, txn_cnt}, {8'd0, exp_cnt});
    step;  // E2: back to IDLE
    chk("acks_e2", {14'd0, ack1, ack0}, 16'd0);
    chk("busy_e2", {15'd0, busy}, 16'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, {14'd0, ack1, ack0}, 16'd0);
    chk({tag, "_res"}, {7'd0, res}, 16'd0);
    chk({tag, "_res_id"}, {15'd0, res_id}, 16'd0);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_cmp"}, {5'd0, cmp_of, cmp_mode, cmp_y, cmp_x}, 16'd0);
    chk({tag, "_txn_cnt"}, {8'd0, txn_cnt}, 16'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'd5,  4'd5, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 9'h001};
    vecs[1] = '{1'b0, 1'b1, 4'd0,  4'd0, 2'd0, 1'b0, 4'd3, 4'd9, 2'd3, 1'b1, 1'b1, 9'h109};
    vecs[2] = '{1'b1, 1'b0, 4'd7,  4'd2, 2'd1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 9'h001};
    vecs[3] = '{1'b1, 1'b0, 4'd2,  4'd7, 2'd1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 9'h000};
    vecs[4] = '{1'b0, 1'b1, 4'd0,  4'd0, 2'd0, 1'b0, 4'd2, 4'd7, 2'd2, 1'b0, 1'b1, 9'h001};
    vecs[5] = '{1'b0, 1'b1, 4'd0,  4'd0, 2'd0, 1'b0, 4'd9, 4'd9, 2'd2, 1'b1, 1'b1, 9'h100};
    vecs[6] = '{1'b1, 1'b0, 4'd12, 4'd3, 2'd3, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 9'h00C};
    vecs[7] = '{1'b0, 1'b1, 4'd0,  4'd0, 2'd0, 1'b0, 4'd4, 4'd4, 2'd0, 1'b1, 1'b1, 9'h101};
    // last_grant is 1 here, so contention goes to 0 in both arbitration modes
    vecs[8] = '{1'b1, 1'b1, 4'd1,  4'd0, 2'd1, 1'b0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0, 9'h001};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    x0 = 4'd0; y0 = 4'd0; x1 = 4'd0; y1 = 4'd0;
    mode0 = 2'd0; mode1 = 2'd0; of0 = 1'b0; of1 = 1'b0;
    exp_cnt = 8'd0;
    #1;
    chk_reset_vals("reset");
    do_reset;
    chk_reset_vals("post_reset");

    // Table-driven single transactions
    for (int i = 0; i < 9; i++) begin
      x0 = vecs[i].vx0; y0 = vecs[i].vy0; mode0 = vecs[i].m0; of0 = vecs[i].o0;
      x1 = vecs[i].vx1; y1 = vecs[i].vy1; mode1 = vecs[i].m1; of1 = vecs[i].o1;
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      run_txn(vecs[i].eid, vecs[i].eres);
      req0 = 1'b0; req1 = 1'b0;
      step;
    end

    // Continuous contention for 4 transactions starting from reset
    do_reset;
    x0 = 4'd7; y0 = 4'd2; mode0 = 2'd1; of0 = 1'b0;
    x1 = 4'd2; y1 = 4'd7; mode1 = 2'd2; of1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef CMP_ARB_RR_EN
      run_txn(k[0], 9'h001);
`else
      run_txn(1'b0, 9'h001);
`endif
    end
    req0 = 1'b0; req1 = 1'b0;
    step;

    // Operand change during ISSUE must not reach the result
    x0 = 4'd5; y0 = 4'd4; mode0 = 2'd3; of0 = 1'b0;
    req0 = 1'b1;
    step;  // E0
    x0 = 4'd0;
    step;  // E1
    exp_cnt = exp_cnt + 8'd1;
    chk("latch_ack0", {15'd0, ack0}, 16'd1);
    chk("latch_res", {7'd0, res}, 16'h0005);
    chk("latch_cnt", {8'd0, txn_cnt}, {8'd0, exp_cnt});
    req0 = 1'b0;
    step;
    step;

    // Reset asserted during ISSUE drops the transaction
    x0 = 4'd6; y0 = 4'd6; mode0 = 2'd0; of0 = 1'b0;
    req0 = 1'b1;
    step;  // E0, now ISSUE
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    step;
    chk("midrst_ack_hold", {14'd0, ack1, ack0}, 16'd0);
    step;
    chk("midrst_ack_hold2", {14'd0, ack1, ack0}, 16'd0);
    rst = 1'b0;
    exp_cnt = 8'd0;
    run_txn(1'b0, 9'h001);
    req0 = 1'b0;
    step;

    // 256 back-to-back transactions wrap the counter
    do_reset;
    x0 = 4'd3; y0 = 4'd3; mode0 = 2'd0; of0 = 1'b1;
    req0 = 1'b1;
    for (int n = 0; n < 256; n++) begin
      run_txn(1'b0, 9'h101);
      if (n == 254) chk("cnt_255", {8'd0, txn_cnt}, 16'd255);
    end
    req0 = 1'b0;
    chk("wrap_zero", {8'd0, txn_cnt}, 16'd0);
    step;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
